// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage.
//   mem_access_state_t : stage FSM states (IDLE, REQ, WAIT, DONE)
//   wb_rec_t           : write-back record (reg_write, rd, data, misalign)
// The record is sized by MA_DATA_W / MA_RD_W. The stage's WIDTH / RD_W
// default to these and must not exceed them.
package mem_access_pkg;

  localparam int MA_DATA_W = 32;
  localparam int MA_RD_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_access_state_t;

  typedef struct packed {
    logic                 reg_write;
    logic [MA_RD_W-1:0]   rd;
    logic [MA_DATA_W-1:0] data;
    logic                 misalign;
  } wb_rec_t;

endpackage

// File: rtl/mem_access_stage.sv
// Memory-access stage. Accepts one decoded instruction at a time, issues at
// most one data-memory request (valid/ready), waits for the single-cycle
// response pulse and presents one write-back record (valid/ready).
// Non-memory ops reach write-back one cycle after acceptance.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid / in_ready              upstream handshake
//   mem_read, mem_write, reg_write   decode bits
//   rd, alu_result, store_data       destination tag, address/result, store data
//   req_valid / req_ready            memory request handshake
//   req_we, req_addr, req_wdata      request fields (registered)
//   resp_valid, resp_rdata           memory response pulse and load data
//   wb_valid / wb_ready              write-back handshake
//   wb_reg_write, wb_rd, wb_data     write-back record
//   misalign                         misaligned-access flag, valid with wb_valid
//
// Configuration macro: MEM_ACCESS_ALIGN_CHECK_EN
//   defined   : memory ops with alu_result[1:0] != 0 skip the request and
//               complete at once with misalign = 1, wb_reg_write = 0.
//   undefined : misalign is always 0; every memory op issues a request.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int WIDTH = MA_DATA_W,
  parameter int RD_W  = MA_RD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic [RD_W-1:0]  rd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] store_data,
  output logic             req_valid,
  input  logic             req_ready,
  output logic             req_we,
  output logic [WIDTH-1:0] req_addr,
  output logic [WIDTH-1:0] req_wdata,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_rdata,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             wb_reg_write,
  output logic [RD_W-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             misalign
);

  mem_access_state_t state_q, state_d;
  wb_rec_t           wb_q, wb_d;
  logic              req_we_q, req_we_d;
  logic [WIDTH-1:0]  req_addr_q, req_addr_d;
  logic [WIDTH-1:0]  req_wdata_q, req_wdata_d;
  logic              accept;

  // DONE can hand off and take a new instruction in the same cycle.
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & wb_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    wb_d        = wb_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;

    case (state_q)
      IDLE: ;
      REQ:  if (req_ready) state_d = WAIT;
      // Responses are only looked at here; strays in other states drop.
      WAIT: if (resp_valid) begin
        state_d = DONE;
        wb_d.data = req_we_q ? MA_DATA_W'(req_wdata_q) : MA_DATA_W'(resp_rdata);
      end
      DONE: if (wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Accept overrides the DONE->IDLE exit for back-to-back operation.
    if (accept) begin
      wb_d.rd        = MA_RD_W'(rd);
      wb_d.data      = MA_DATA_W'(alu_result);
      wb_d.reg_write = reg_write;
      wb_d.misalign  = 1'b0;
      req_addr_d     = alu_result;
      req_wdata_d    = store_data;
      req_we_d       = mem_write;  // store wins when both decode bits set
      if (mem_read | mem_write) begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        if (alu_result[1:0] != 2'b00) begin
          state_d        = DONE;
          wb_d.misalign  = 1'b1;
          wb_d.reg_write = 1'b0;
        end else begin
`else
        begin
`endif
          state_d        = REQ;
          wb_d.reg_write = reg_write & ~mem_write;
        end
      end else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wb_q        <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  assign req_valid    = (state_q == REQ);
  assign req_we       = req_we_q;
  assign req_addr     = req_addr_q;
  assign req_wdata    = req_wdata_q;
  assign wb_valid     = (state_q == DONE);
  assign wb_reg_write = wb_q.reg_write;
  assign wb_rd        = RD_W'(wb_q.rd);
  assign wb_data      = WIDTH'(wb_q.data);
  assign misalign     = wb_q.misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage. Expected write-back records are queued when
// an instruction is driven and compared by a monitor on each wb handshake;
// scenario tasks check request-side and handshake behaviour inline.
module tb_mem_access_stage;

  localparam int W = 32;
  localparam int R = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic         mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
  logic [R-1:0] rd = '0;
  logic [W-1:0] alu_result = '0, store_data = '0;
  logic         req_valid, req_ready = 1'b0, req_we;
  logic [W-1:0] req_addr, req_wdata;
  logic         resp_valid = 1'b0;
  logic [W-1:0] resp_rdata = '0;
  logic         wb_valid, wb_ready = 1'b0, wb_reg_write;
  logic [R-1:0] wb_rd;
  logic [W-1:0] wb_data;
  logic         misalign;

  typedef struct {
    logic         rw;
    logic [R-1:0] rd;
    logic [W-1:0] data;
    logic         mis;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_access_stage #(.WIDTH(W), .RD_W(R)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .rd(rd), .alu_result(alu_result), .store_data(store_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Scoreboard: one record consumed per write-back handshake.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL wb_scoreboard: unexpected record rw=%b rd=%0d data=%h mis=%b",
                 wb_reg_write, wb_rd, wb_data, misalign);
      end else begin
        mon_e = sbq.pop_front();
        if ({wb_reg_write, wb_rd, wb_data, misalign} !== {mon_e.rw, mon_e.rd, mon_e.data, mon_e.mis}) begin
          n_fail++;
          $display("FAIL wb_scoreboard: got rw=%b rd=%0d data=%h mis=%b, want rw=%b rd=%0d data=%h mis=%b",
                   wb_reg_write, wb_rd, wb_data, misalign, mon_e.rw, mon_e.rd, mon_e.data, mon_e.mis);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive_op(input logic mr, input logic mw, input logic rw,
                          input logic [R-1:0] d, input logic [W-1:0] a, input logic [W-1:0] s);
    in_valid = 1'b1; mem_read = mr; mem_write = mw; reg_write = rw;
    rd = d; alu_result = a; store_data = s;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_valid, req_we, req_addr, req_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, misalign} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req_v=%b we=%b addr=%h wd=%h wb_v=%b rw=%b rd=%0d data=%h mis=%b, want all 0",
               req_valid, req_we, req_addr, req_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, misalign);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // First op is the plain non-memory case; the rest stream one per cycle.
  task automatic test_back_to_back();
    logic [W-1:0] v;
    wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      v = (i == 0) ? 32'h1234 : (32'hA000_0000 + i);
      drive_op(1'b0, 1'b0, (i != 3), (i == 0) ? 3'd5 : R'(i), v, 32'h0);
      sbq.push_back('{rw: (i != 3), rd: (i == 0) ? 3'd5 : R'(i), data: v, mis: 1'b0});
      if (i > 0) begin
        @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_wb_valid[%0d]: got %b want 1", i, wb_valid);
        end
      end
    end
    @(posedge clk); #1 idle_in();
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_last_wb_valid: got %b want 1", wb_valid);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: wb_valid got %b want 0", wb_valid);
    end
  endtask

  task automatic test_load();
    wb_ready = 1'b1;
    @(posedge clk); #1 drive_op(1'b1, 1'b0, 1'b1, 3'd3, 32'h100, 32'h5555);
    @(posedge clk); #1 idle_in();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) req_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({req_valid, req_we, req_addr} !== {1'b1, 1'b0, 32'h100}) begin
        n_fail++;
        $display("FAIL load_req[%0d]: valid=%b we=%b addr=%h want 1 0 00000100", k, req_valid, req_we, req_addr);
      end
      n_checks++;
      if (wb_valid !== 1'b0) begin
        n_fail++; $display("FAIL load_no_wb[%0d]: wb_valid got %b want 0", k, wb_valid);
      end
      @(posedge clk); #1;
    end
    req_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_wait_req: req_valid got %b want 0", req_valid);
    end
    @(posedge clk); #1;  // one extra cycle of waiting
    resp_valid = 1'b1; resp_rdata = 32'hDEADBEEF;
    sbq.push_back('{rw: 1'b1, rd: 3'd3, data: 32'hDEADBEEF, mis: 1'b0});
    @(posedge clk); #1 resp_valid = 1'b0; resp_rdata = '0;
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b1) begin
      n_fail++; $display("FAIL load_wb_valid: got %b want 1", wb_valid);
    end
    @(posedge clk); #1;
  endtask

  // also_read sets both decode bits; the store must still win.
  task automatic test_store(input logic also_read);
    wb_ready = 1'b1;
    @(posedge clk); #1 drive_op(also_read, 1'b1, 1'b1, 3'd6, 32'h200, 32'hCAFE);
    @(posedge clk); #1 idle_in();
    resp_valid = 1'b1; resp_rdata = 32'hBAD0BAD0;  // stray response while in REQ
    @(negedge clk);
    n_checks++;
    if ({req_valid, req_we, req_addr, req_wdata} !== {1'b1, 1'b1, 32'h200, 32'hCAFE}) begin
      n_fail++;
      $display("FAIL store_req(rd=%b): valid=%b we=%b addr=%h wdata=%h want 1 1 00000200 0000cafe",
               also_read, req_valid, req_we, req_addr, req_wdata);
    end
    @(posedge clk); #1 resp_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_valid, wb_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL store_stray_resp(rd=%b): req_valid=%b wb_valid=%b want 1 0", also_read, req_valid, wb_valid);
    end
    @(posedge clk); #1 req_ready = 1'b0;
    resp_valid = 1'b1;
    sbq.push_back('{rw: 1'b0, rd: 3'd6, data: 32'hCAFE, mis: 1'b0});
    @(posedge clk); #1 resp_valid = 1'b0; resp_rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({wb_valid, wb_reg_write} !== 2'b10) begin
      n_fail++;
      $display("FAIL store_wb(rd=%b): wb_valid=%b wb_reg_write=%b want 1 0", also_read, wb_valid, wb_reg_write);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wb_stall();
    wb_ready = 1'b0;
    @(posedge clk); #1 drive_op(1'b0, 1'b0, 1'b1, 3'd2, 32'h7777, 32'h0);
    sbq.push_back('{rw: 1'b1, rd: 3'd2, data: 32'h7777, mis: 1'b0});
    @(posedge clk); #1 drive_op(1'b0, 1'b0, 1'b1, 3'd4, 32'h8888, 32'h0);
    sbq.push_back('{rw: 1'b1, rd: 3'd4, data: 32'h8888, mis: 1'b0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({wb_valid, in_ready, wb_reg_write, wb_rd, wb_data} !== {1'b1, 1'b0, 1'b1, 3'd2, 32'h7777}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: wb_v=%b in_rdy=%b rw=%b rd=%0d data=%h want 1 0 1 2 00007777",
                 k, wb_valid, in_ready, wb_reg_write, wb_rd, wb_data);
      end
      if (k < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 wb_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1 idle_in();
    @(negedge clk);
    n_checks++;
    if ({wb_valid, wb_data} !== {1'b1, 32'h8888}) begin
      n_fail++; $display("FAIL stall_next_accepted: wb_v=%b data=%h want 1 00008888", wb_valid, wb_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b1;
    @(posedge clk); #1 drive_op(1'b1, 1'b0, 1'b1, 3'd7, 32'h300, 32'h0);
    @(posedge clk); #1 idle_in(); req_ready = 1'b1;
    @(posedge clk); #1 req_ready = 1'b0; rst = 1'b1;   // now in WAIT
    @(posedge clk); #1 rst = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h1111_2222;
    @(posedge clk); #1 resp_valid = 1'b0; resp_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({req_valid, req_we, req_addr, req_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, misalign} !== '0) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: req_v=%b we=%b addr=%h wd=%h wb_v=%b rw=%b rd=%0d data=%h mis=%b, want all 0",
                 k, req_valid, req_we, req_addr, req_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, misalign);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_mid_idle[%0d]: in_ready got %b want 1", k, in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_align();
    wb_ready = 1'b1;
    @(posedge clk); #1 drive_op(1'b1, 1'b0, 1'b1, 3'd1, 32'h103, 32'h0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    sbq.push_back('{rw: 1'b0, rd: 3'd1, data: 32'h103, mis: 1'b1});
    @(posedge clk); #1 idle_in();
    @(negedge clk);
    n_checks++;
    if ({req_valid, wb_valid, misalign, wb_reg_write} !== 4'b0110) begin
      n_fail++;
      $display("FAIL align_misaligned: req_v=%b wb_v=%b mis=%b rw=%b want 0 1 1 0",
               req_valid, wb_valid, misalign, wb_reg_write);
    end
    @(posedge clk); #1;
`else
    @(posedge clk); #1 idle_in(); req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_valid, req_addr, misalign} !== {1'b1, 32'h103, 1'b0}) begin
      n_fail++;
      $display("FAIL align_passthru: req_v=%b addr=%h mis=%b want 1 00000103 0", req_valid, req_addr, misalign);
    end
    @(posedge clk); #1 req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h0BAD_F00D;
    sbq.push_back('{rw: 1'b1, rd: 3'd1, data: 32'h0BAD_F00D, mis: 1'b0});
    @(posedge clk); #1 resp_valid = 1'b0; resp_rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({wb_valid, misalign} !== 2'b10) begin
      n_fail++; $display("FAIL align_wb: wb_v=%b mis=%b want 1 0", wb_valid, misalign);
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load();
    test_store(1'b0);
    test_store(1'b1);
    test_wb_stall();
    test_reset_mid();
    test_align();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d records outstanding, want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage sitting directly downstream of the control unit and ALU. Consumes `memRead`/`memWrite`/`regWrite` decode bits plus the ALU result and store data. Issues at most one data-memory request at a time over a valid/ready handshake, waits for the memory response, and hands a single write-back record to the next stage. Non-memory instructions pass through with one-cycle latency.

## Interface
- `WIDTH`, 32: data and address width in bits.
- `RD_W`, 3: destination-register tag width, matching the control unit's `regDst`.
- `clk` input 1: the single clock. Reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream instruction is valid.
- `in_ready` output 1: stage accepts the instruction this cycle.
- `mem_read`, `mem_write`, `reg_write` input 1 each: decode bits from the control unit.
- `rd` input RD_W: destination tag.
- `alu_result` input WIDTH: effective address for memory ops; result value for other ops.
- `store_data` input WIDTH: store data.
- `req_valid` output 1 and `req_ready` input 1: data-memory request handshake.
- `req_we` output 1: 1 for a store, 0 for a load.
- `req_addr` output WIDTH: request address.
- `req_wdata` output WIDTH: request store data.
- `resp_valid` input 1: memory response; a single-cycle pulse that acknowledges both loads and stores.
- `resp_rdata` input WIDTH: load data, valid while `resp_valid` is high.
- `wb_valid` output 1 and `wb_ready` input 1: write-back handshake.
- `wb_reg_write` output 1: write-back enable.
- `wb_rd` output RD_W: write-back destination tag.
- `wb_data` output WIDTH: write-back data.
- `misalign` output 1: misaligned-access flag, valid with `wb_valid`.

## Operation
- States are IDLE, REQ, WAIT and DONE.
- **in_ready**: `in_ready = (state==IDLE) | (state==DONE & wb_ready)`.
- **Accept**: on `in_valid & in_ready`, latch all inputs.
  - If `mem_read | mem_write` → REQ.
  - Otherwise → DONE with `wb_data = alu_result` and `wb_reg_write = reg_write`.
- **Both decode bits set**: if `mem_read & mem_write` are both 1, the store wins (`req_we = 1`).
- **REQ**: `req_valid = 1`. `req_addr`, `req_wdata` and `req_we` stay stable until `req_ready`. On the handshake → WAIT.
- **WAIT**: `resp_valid` is sampled only in this state. On `resp_valid` → DONE.
  - Load: `wb_data = resp_rdata`, `wb_reg_write = reg_write`.
  - Store: `wb_reg_write = 0`, and `wb_data` holds the store data.
- **DONE**: `wb_valid = 1` and all wb fields stay stable until `wb_ready`.
  - If `wb_ready` with no new accept → IDLE.
  - If `wb_ready` with a new accept → follow the Accept rule, which gives back-to-back operation.
- **Ignored responses**: a `resp_valid` seen in IDLE, REQ or DONE is ignored. A response in REQ is a memory protocol violation.
- **Reset**: applies in any state, including mid-transaction.
  - State → IDLE.
  - `req_valid`, `wb_valid`, `wb_reg_write`, `misalign`, `req_we` = 0.
  - `req_addr`, `req_wdata`, `wb_rd`, `wb_data` = 0.
  - A late response after reset is dropped.
- **Width rules**: no arithmetic is performed; addresses are passed through unmodified at WIDTH bits.

## Timing
- Non-memory op: `wb_valid` rises 1 cycle after acceptance. Sustained throughput is 1 op per cycle while `wb_ready = 1`.
- Memory op:
  - `req_valid` rises 1 cycle after acceptance.
  - WAIT is entered the cycle after `req_ready`.
  - `wb_valid` rises the cycle after `resp_valid`.
  - Minimum latency from accept to `wb_valid` is 3 cycles.
- All outputs are registered or decoded from state only. There are no combinational paths from `req_ready`/`resp_*` to `req_*`/`wb_*`.
- The only combinational input dependency is `in_ready` on `wb_ready`.

## Configuration
- Controlled by the macro `MEM_ACCESS_ALIGN_CHECK_EN`.
- **Defined**: at accept, a memory op with `alu_result[1:0] != 0` issues no request. It goes straight to DONE with `misalign = 1`, `wb_reg_write = 0` and `wb_data = alu_result`. `misalign` is held with `wb_valid`.
- **Undefined**: `misalign` is tied to 0 and every memory op issues a request with the address unmodified.

## Structure
- Shared package `mem_access_pkg` holds:
  - the state enum `mem_access_state_t` (IDLE, REQ, WAIT, DONE);
  - the packed struct `wb_rec_t` carrying reg_write, rd, data and misalign.
- The block is a single module; no sub-module is warranted.

## Test plan
- Non-memory op: `alu_result = 0x1234`, `reg_write = 1`, `rd = 5`, `wb_ready = 1` → `wb_valid` the next cycle with `wb_data = 0x1234` and `wb_rd = 5`. Back-to-back ops give `wb_valid` every cycle.
- Load to `0x100`: `req_ready` is delayed 2 cycles and `resp_rdata = 0xDEADBEEF` → `req_addr` stays stable at `0x100` throughout, and `wb_data = 0xDEADBEEF` with `wb_reg_write = 1` the cycle after `resp_valid`.
- Store of `0xCAFE` to `0x200` → `req_we = 1` and `req_wdata = 0xCAFE`, then `wb_valid` with `wb_reg_write = 0` after the response.
- `wb_ready` is held low for 3 cycles in DONE → `in_ready = 0` and the wb fields stay stable. When `wb_ready` rises, the next instruction is accepted the same cycle.
- `rst` pulsed during WAIT, followed by a `resp_valid` one cycle later → state is IDLE, no `wb_valid` is produced, and all outputs read 0.
- With `MEM_ACCESS_ALIGN_CHECK_EN` defined, a load to `0x103` → no `req_valid`, and the next cycle shows `wb_valid = 1`, `misalign = 1`, `wb_reg_write = 0`.
